// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the EX-stage branch-resolution controller:
//   - B-type funct3 encodings (F3_BEQ .. F3_BGEU)
//   - 2-bit branch history counter values (SNT, WNT, WT, ST)
//   - controller FSM state enum (ctrl_state_e)
//   - small helpers for branch legality, outcome and counter update
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  // funct3 010 and 011 are the only undefined B-type encodings
  function automatic logic br_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

  // Branch outcome from the comparator flags; lt is already signed/unsigned
  // according to funct3[1]
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic       eq,
                                    input logic       lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

  // Saturating 2-bit counter step
  function automatic logic [1:0] bht_next(input logic [1:0] cur,
                                          input logic       taken);
    logic [1:0] n;
    if (taken) n = (cur == ST)  ? ST  : cur + 2'b01;
    else       n = (cur == SNT) ? SNT : cur - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_cmp_un.sv
// ---------------------------------------------------------------------------
// branch_cmp_un
// Combinational branch comparator.
// Ports:
//   data1, data2 : operands (rs1, rs2)
//   br_un        : 1 = unsigned less-than, 0 = signed less-than
//   br_eq        : data1 == data2
//   br_lt        : data1 < data2 under the selected signedness
// ---------------------------------------------------------------------------
module branch_cmp_un #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            br_un,
  output logic            br_eq,
  output logic            br_lt
);

  always_comb begin
    br_eq = (data1 == data2);
    if (br_un) br_lt = (data1 < data2);
    else       br_lt = ($signed(data1) < $signed(data2));
  end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// EX-stage branch-resolution controller. Resolves one conditional branch per
// cycle, checks it against the IF prediction, issues a PC redirect and holds
// a front-end flush on a mispredict, and owns the 2-bit branch history table
// plus the branch / mispredict performance counters.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   if_pc              : fetch PC for the BHT lookup
//   if_pred_taken      : combinational prediction, counter[1] of entry(if_pc)
//   ex_valid, ex_ready : branch handshake (accept = ex_valid & ex_ready)
//   ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken : branch in EX
//   redirect           : one-cycle pulse, load redirect_pc into the PC
//   redirect_pc        : corrected PC, held until the next mispredict
//   flush              : squash IF/ID, held FLUSH_CYCLES cycles
//   br_count, mis_count: saturating retired-branch / mispredict counters
// ---------------------------------------------------------------------------
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_IDX_W    = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     br_count,
  output logic [31:0]     mis_count
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  ctrl_state_e            state;
  logic [CNT_W-1:0]       flush_cnt;
  logic [1:0]             bht [BHT_N];

  logic [BHT_IDX_W-1:0]   if_idx;
  logic [BHT_IDX_W-1:0]   ex_idx;
  logic                   br_eq;
  logic                   br_lt;
  logic                   legal;
  logic                   taken;
  logic                   mispredict;
  logic                   update;
  logic [XLEN-1:0]        target;

  // The BHT index ignores the two always-zero PC bits and the upper PC bits
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

  assign if_idx        = if_pc[BHT_IDX_W+1:2];
  assign ex_idx        = ex_pc[BHT_IDX_W+1:2];
  // Read-before-write: the lookup sees the table state before this cycle's update
  assign if_pred_taken = bht[if_idx][1];
  assign ex_ready      = (state == IDLE);

  branch_cmp_un #(.XLEN(XLEN)) u_cmp (
    .data1 (ex_rs1),
    .data2 (ex_rs2),
    .br_un (ex_funct3[1]),
    .br_eq (br_eq),
    .br_lt (br_lt)
  );

  always_comb begin
    legal      = br_legal(ex_funct3);
    taken      = br_taken(ex_funct3, br_eq, br_lt);
    mispredict = (taken != ex_pred_taken);
    update     = ex_valid & ex_ready & legal;
    target     = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
  end

  // Controller FSM; redirect and flush are registered so a mispredict accepted
  // at one edge shows up on both outputs right after that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          redirect <= 1'b0;
          flush    <= 1'b0;
          if (update && mispredict) begin
            state       <= FLUSH;
            flush_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            redirect    <= 1'b1;
            flush       <= 1'b1;
            redirect_pc <= target;
          end
        end
        FLUSH: begin
          redirect <= 1'b0;
          if (flush_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Branch history table, trained by every accepted legal branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= WNT;
    end else if (update) begin
      bht[ex_idx] <= bht_next(bht[ex_idx], taken);
    end
  end

  // Performance counters, both saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (update) begin
      if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
      if (mispredict && (mis_count != 32'hFFFF_FFFF)) mis_count <= mis_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl: a behavioural reference model checked
// against the DUT on every negative clock edge, plus directed literal checks.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN         = 32;
  localparam int BHT_IDX_W    = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int BHT_N        = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_ready;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            ex_pred_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     br_count;
  logic [31:0]     mis_count;

  always #5 clk = ~clk;

  branch_ctrl #(
    .BHT_IDX_W    (BHT_IDX_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .XLEN         (XLEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_funct3     (ex_funct3),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_pred_taken (ex_pred_taken),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .br_count      (br_count),
    .mis_count     (mis_count)
  );

  int compare_count  = 0;
  int mismatch_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_bht [BHT_N];
  logic [31:0] m_br;
  logic [31:0] m_mis;
  logic [31:0] m_rpc;
  int          m_flush_left;
  bit          m_redirect;
  bit          m_tk;
  int          m_idx;

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % BHT_N);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return !($signed(a) < $signed(b));
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
      m_br = 0; m_mis = 0; m_rpc = 0; m_flush_left = 0; m_redirect = 0;
    end else begin
      m_redirect = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (ex_valid && (ex_funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7})) begin
        m_tk  = model_taken(ex_funct3, ex_rs1, ex_rs2);
        m_idx = bidx(ex_pc);
        if (m_tk) m_bht[m_idx] = (m_bht[m_idx] == 3) ? 3 : m_bht[m_idx] + 1;
        else      m_bht[m_idx] = (m_bht[m_idx] == 0) ? 0 : m_bht[m_idx] - 1;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (m_tk != ex_pred_taken) begin
          if (m_mis != 32'hFFFF_FFFF) m_mis++;
          m_flush_left = FLUSH_CYCLES;
          m_redirect   = 1;
          m_rpc        = m_tk ? ex_pc + ex_imm : ex_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("cyc_ex_ready", {31'd0, ex_ready}, {31'd0, m_flush_left == 0});
      checkOutput("cyc_flush", {31'd0, flush}, {31'd0, m_flush_left > 0});
      checkOutput("cyc_redirect", {31'd0, redirect}, {31'd0, m_redirect});
      checkOutput("cyc_redirect_pc", redirect_pc, m_rpc);
      checkOutput("cyc_br_count", br_count, m_br);
      checkOutput("cyc_mis_count", mis_count, m_mis);
      checkOutput("cyc_if_pred", {31'd0, if_pred_taken}, {31'd0, m_bht[bidx(if_pc)] >= 2});
    end
  end

  // ---------------- stimulus ----------------
  task automatic driveInputs(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] a,
                             input logic [31:0] b, input logic pred);
    ex_valid = v; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pred;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] a,
                               input logic [31:0] b, input logic pred);
    driveInputs(v, f3, pc, imm, a, b, pred);
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle();
    ex_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    if_pc = '0;
    driveInputs(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("rst_br_count", br_count, 32'd0);
    checkOutput("rst_mis_count", mis_count, 32'd0);

    // BEQ taken, predicted not taken -> mispredict
    applyStimulus(1'b1, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    checkOutput("beq_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h120);
    checkOutput("beq_flush1", {31'd0, flush}, 32'd1);
    checkOutput("beq_ready1", {31'd0, ex_ready}, 32'd0);
    checkOutput("beq_br_count", br_count, 32'd1);
    checkOutput("beq_mis_count", mis_count, 32'd1);
    idleCycle();
    checkOutput("beq_redirect2", {31'd0, redirect}, 32'd0);
    checkOutput("beq_flush2", {31'd0, flush}, 32'd1);
    checkOutput("beq_ready2", {31'd0, ex_ready}, 32'd0);
    idleCycle();
    checkOutput("beq_flush3", {31'd0, flush}, 32'd0);
    checkOutput("beq_ready3", {31'd0, ex_ready}, 32'd1);

    // Signed vs unsigned compare of 0xFFFFFFFF against 1
    applyStimulus(1'b1, F3_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checkOutput("blt_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("blt_flush", {31'd0, flush}, 32'd0);
    applyStimulus(1'b1, F3_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checkOutput("bltu_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("bltu_redirect_pc", redirect_pc, 32'h204);
    checkOutput("bltu_mis_count", mis_count, 32'd2);
    idleCycle();
    idleCycle();

    // BHT saturation at pc 0x40, including same-cycle lookup/update
    if_pc = 32'h40;
    driveInputs(1'b1, F3_BNE, 32'h40, 32'h10, 32'd1, 32'd2, 1'b1);
    #1;
    checkOutput("bht_read_before_write", {31'd0, if_pred_taken}, 32'd0);
    @(posedge clk);
    #2;
    checkOutput("bht_after_1_taken", {31'd0, if_pred_taken}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, F3_BNE, 32'h40, 32'h10, 32'd1, 32'd2, 1'b1);
    checkOutput("bht_after_4_taken", {31'd0, if_pred_taken}, 32'd1);
    applyStimulus(1'b1, F3_BNE, 32'h40, 32'h10, 32'd9, 32'd9, 1'b0);
    checkOutput("bht_nt1", {31'd0, if_pred_taken}, 32'd1);
    applyStimulus(1'b1, F3_BNE, 32'h40, 32'h10, 32'd9, 32'd9, 1'b0);
    checkOutput("bht_nt2", {31'd0, if_pred_taken}, 32'd0);
    applyStimulus(1'b1, F3_BNE, 32'h40, 32'h10, 32'd9, 32'd9, 1'b0);
    // One taken step from a saturated 00 lands at 01, still not-taken
    applyStimulus(1'b1, F3_BNE, 32'h40, 32'h10, 32'd1, 32'd2, 1'b1);
    checkOutput("bht_floor", {31'd0, if_pred_taken}, 32'd0);
    checkOutput("bht_br_count", br_count, 32'd11);
    checkOutput("bht_mis_count", mis_count, 32'd2);

    // Eight back-to-back correctly predicted branches
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b1, F3_BEQ, 32'h300 + 32'(4 * i), 32'h8, 32'd7, 32'd7, 1'b1);
      else
        applyStimulus(1'b1, F3_BGEU, 32'h300 + 32'(4 * i), 32'h8, 32'd3, 32'd7, 1'b0);
    end
    checkOutput("b2b_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("b2b_flush", {31'd0, flush}, 32'd0);
    checkOutput("b2b_br_count", br_count, 32'd19);
    checkOutput("b2b_mis_count", mis_count, 32'd2);

    // Target wrap-around
    applyStimulus(1'b1, F3_BEQ, 32'hFFFF_FFF0, 32'h20, 32'd4, 32'd4, 1'b0);
    checkOutput("wrap_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("wrap_redirect_pc", redirect_pc, 32'h10);
    idleCycle();
    idleCycle();

    // Illegal funct3 is accepted but changes nothing
    applyStimulus(1'b1, 3'b010, 32'h40, 32'h20, 32'd4, 32'd4, 1'b1);
    checkOutput("ill_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("ill_flush", {31'd0, flush}, 32'd0);
    checkOutput("ill_br_count", br_count, 32'd20);
    checkOutput("ill_mis_count", mis_count, 32'd3);
    checkOutput("ill_redirect_pc", redirect_pc, 32'h10);
    checkOutput("ill_bht", {31'd0, if_pred_taken}, 32'd0);
    idleCycle();

    // Reset asserted during the second flush cycle
    if_pc = 32'h100;
    #1;
    checkOutput("pre_rst_bht0", {31'd0, if_pred_taken}, 32'd1);
    applyStimulus(1'b1, F3_BEQ, 32'h500, 32'h8, 32'd1, 32'd2, 1'b1);
    checkOutput("mid_redirect_pc", redirect_pc, 32'h504);
    idleCycle();
    checkOutput("mid_flush", {31'd0, flush}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_flush", {31'd0, flush}, 32'd0);
    checkOutput("arst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("arst_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("arst_br_count", br_count, 32'd0);
    checkOutput("arst_mis_count", mis_count, 32'd0);
    checkOutput("arst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("arst_bht0", {31'd0, if_pred_taken}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    if_pc = 32'h40;
    // Entry back at 01, so one taken step flips the prediction
    applyStimulus(1'b1, F3_BNE, 32'h40, 32'h0, 32'd1, 32'd2, 1'b1);
    checkOutput("post_rst_bht", {31'd0, if_pred_taken}, 32'd1);
    checkOutput("post_rst_br_count", br_count, 32'd1);
    idleCycle();
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch-resolution controller in the EX stage of the 5-stage RV32I pipeline.
- Accepts one conditional branch per cycle and evaluates it through an embedded comparator that supports signed and unsigned compares.
- Checks the outcome against the prediction carried down the pipe. On a mispredict it issues the PC redirect and sequences the front-end flush.
- Owns the branch history table (2-bit counters) that the IF stage reads for prediction, plus branch and mispredict performance counters.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries; index = pc[BHT_IDX_W+1:2]
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (>=1)
- XLEN, 32, datapath width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational BHT lookup: counter[1] of entry(if_pc)
- ex_valid  in  1  branch instruction present in EX
- ex_ready  out  1  controller can accept this cycle
- ex_funct3  in  3  B-type funct3
- ex_pc  in  XLEN  PC of the branch
- ex_imm  in  XLEN  sign-extended B-immediate
- ex_rs1  in  XLEN  forwarded rs1 value
- ex_rs2  in  XLEN  forwarded rs2 value
- ex_pred_taken  in  1  prediction made at IF for this branch
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  XLEN  corrected PC
- flush  out  1  squash IF/ID contents
- br_count  out  32  retired valid branches
- mis_count  out  32  mispredicted branches

Behaviour:
- Clock and reset:
  - One clock domain, clk. Reset is rst_n, asynchronous assert, active-low, synchronous deassert by the system.
  - Reset values: state=IDLE, redirect=0, redirect_pc=0, flush=0, br_count=0, mis_count=0, every BHT entry=2'b01 (weakly not-taken).
  - ex_ready=1 after reset.
- Accept: ex_valid & ex_ready at a rising edge.
- Branch decode from funct3:
  - Taken conditions: 000 BEQ (eq), 001 BNE (!eq), 100 BLT (signed lt), 101 BGE (!signed lt), 110 BLTU (unsigned lt), 111 BGEU (!unsigned lt).
  - funct3 010/011 are illegal. The instruction is accepted but has no effect: no counter change, no BHT update, no redirect.
- Comparator:
  - eq = rs1==rs2.
  - lt = signed or unsigned compare, selected by br_un = funct3[1].
  - Purely combinational, same cycle as accept.
- Target: taken → ex_pc+ex_imm, modulo 2^XLEN (wrap silently); not taken → ex_pc+4.
- mispredict = taken != ex_pred_taken.
- FSM states: IDLE and FLUSH.
  - IDLE: ex_ready=1.
    - Accept with no mispredict: stay IDLE. Back-to-back accepts are allowed every cycle.
    - Accept with a mispredict: go to FLUSH, load the flush counter with FLUSH_CYCLES-1, register redirect_pc.
  - FLUSH: ex_ready=0 and flush=1 for exactly FLUSH_CYCLES cycles. The counter decrements each cycle; return to IDLE after the cycle in which it reads 0.
    - redirect=1 only in the first FLUSH cycle.
    - redirect_pc holds its value until the next mispredict.
  - Latency: a mispredict accepted at edge N drives redirect and flush starting at cycle N+1, both registered.
  - ex_valid while in FLUSH is ignored (not accepted).
- BHT update on every accepted legal branch, at the accept edge:
  - Taken: saturating increment (max 11).
  - Not taken: saturating decrement (min 00).
  - If if_pc and ex_pc hit the same entry in the same cycle, if_pred_taken shows the pre-update value (read-before-write).
- Performance counters:
  - br_count increments on every accepted legal branch.
  - mis_count increments additionally when that branch mispredicts.
  - Both saturate at 32'hFFFF_FFFF with no wrap.
- Reset asserted mid-FLUSH: return to IDLE immediately, flush/redirect go to 0, BHT and counters return to their reset values.

Decomposition:
- Shared package (pipeline pkg):
  - funct3 branch encodings F3_BEQ..F3_BGEU.
  - BHT counter constants SNT=00, WNT=01, WT=10, ST=11.
  - ctrl_state_e enum {IDLE, FLUSH}.
- One sub-module, branch_cmp_un:
  - Inputs data1, data2, br_un.
  - Outputs br_eq, br_lt (signed lt when br_un=0).
  - Instantiated once.

Test Plan:
- Reset, then BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred=0 → mispredict; redirect=1 for one cycle with redirect_pc=0x120; flush=1 for 2 cycles; ex_ready=0 for 2 cycles; mis_count=1, br_count=1.
- Signed vs. unsigned with rs1=0xFFFF_FFFF, rs2=1, pred=1:
  - BLT → taken, no redirect, no flush.
  - Same operands with BLTU, pred=1 → not taken, redirect_pc=pc+4.
- BHT saturation: 4 taken BNE at pc=0x40 → entry goes 01→10→11→11 and if_pred_taken(0x40)=1. Then 3 not-taken → entry 00. Same-cycle lookup and update returns the old value.
- 8 consecutive correctly predicted branches on consecutive cycles → ex_ready stays 1, no flush, br_count=8, mis_count=0.
- Target wrap and illegal funct3:
  - pc=0xFFFF_FFF0, imm=0x20, taken mispredict → redirect_pc=0x0000_0010.
  - funct3=010 accepted → no counter or BHT change, no redirect.
- Assert rst_n during the second FLUSH cycle → flush=0 and redirect=0 asynchronously, ex_ready=1, counters=0, all BHT entries=01.
